countdown_timer: RTL and testbench

//   MM:SS BCD countdown timer paced by the one-cycle strobe from the pulse

---
 rtl/timer_pkg.sv | 23 ++
 rtl/bcd_digit_down.sv | 42 ++++
 rtl/countdown_timer.sv | 146 ++++++++++++++
 tb/tb_countdown_timer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types, state encoding and preset helpers for the MM:SS countdown timer.
package timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  typedef logic [3:0] bcd_t;
  typedef logic [7:0] bcd_pair_t;

  localparam bcd_t BCD_MAX_SEC_TENS = 4'd5;
  localparam bcd_t BCD_MAX_DIGIT    = 4'd9;

  function automatic logic bcd_digit_ok(input bcd_t d, input bcd_t max_d);
    return d <= max_d;
  endfunction

  function automatic int bcd_pair_value(input bcd_pair_t p);
    return int'(p[7:4]) * 10 + int'(p[3:0]);
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit: wraps to MAX when decremented from zero and
// reports that wrap as a borrow to the next more significant digit.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter bcd_t MAX = BCD_MAX_DIGIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       zero,
  output logic       borrow
);

  bcd_t q_q, q_d;

  // Load takes precedence so a preset can never be disturbed by a decrement.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (en) begin
      q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign zero   = (q_q == 4'd0);
  assign borrow = en && (q_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: control FSM, preset validation and output pulses
// around a chain of four borrow-linked BCD digits.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] state,
  output logic       expired,
  output logic       alarm,
  output logic       load_err
);

  logic [1:0] state_q, state_d;
  logic       expired_q, expired_d;
  logic       alarm_q, alarm_d;
  logic       load_err_q, load_err_d;

  logic       preset_valid;
  logic       do_load;
  logic       do_dec;
  logic       count_zero;
  logic       count_one;

  bcd_t       sec_ones, sec_tens, min_ones, min_tens;
  logic       sec_ones_zero, sec_tens_zero, min_ones_zero, min_tens_zero;
  logic       sec_ones_borrow, sec_tens_borrow, min_ones_borrow;
  logic       min_tens_borrow_unused;

  always_comb begin
    preset_valid = bcd_digit_ok(preset_min[7:4], BCD_MAX_DIGIT) &&
                   bcd_digit_ok(preset_min[3:0], BCD_MAX_DIGIT) &&
                   bcd_digit_ok(preset_sec[7:4], BCD_MAX_SEC_TENS) &&
                   bcd_digit_ok(preset_sec[3:0], BCD_MAX_DIGIT) &&
                   (bcd_pair_value(preset_min) <= MAX_MIN);
  end

  assign count_zero = sec_ones_zero && sec_tens_zero && min_ones_zero && min_tens_zero;
  assign count_one  = (sec_ones == 4'd1) && sec_tens_zero && min_ones_zero && min_tens_zero;

  // Strobes are resolved load > pause > start > tick; a strobe that is not
  // meaningful in the current state falls through to the next one.
  always_comb begin
    state_d    = state_q;
    do_load    = 1'b0;
    do_dec     = 1'b0;
    load_err_d = 1'b0;
    expired_d  = 1'b0;
    if (load) begin
      if (preset_valid) begin
        do_load = 1'b1;
        state_d = ST_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (start && ((state_q == ST_IDLE) || (state_q == ST_PAUSE)) && !count_zero) begin
      state_d = ST_RUN;
    end else if (tick && (state_q == ST_RUN) && !count_zero) begin
      do_dec = 1'b1;
      if (count_one) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end
    end
    alarm_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      expired_q  <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      expired_q  <= expired_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
    end
  end

  bcd_digit_down #(.MAX(BCD_MAX_DIGIT)) u_sec_ones (
    .clk    (clk),
    .rst    (rst),
    .en     (do_dec),
    .ld     (do_load),
    .ld_val (preset_sec[3:0]),
    .q      (sec_ones),
    .zero   (sec_ones_zero),
    .borrow (sec_ones_borrow)
  );

  bcd_digit_down #(.MAX(BCD_MAX_SEC_TENS)) u_sec_tens (
    .clk    (clk),
    .rst    (rst),
    .en     (sec_ones_borrow),
    .ld     (do_load),
    .ld_val (preset_sec[7:4]),
    .q      (sec_tens),
    .zero   (sec_tens_zero),
    .borrow (sec_tens_borrow)
  );

  bcd_digit_down #(.MAX(BCD_MAX_DIGIT)) u_min_ones (
    .clk    (clk),
    .rst    (rst),
    .en     (sec_tens_borrow),
    .ld     (do_load),
    .ld_val (preset_min[3:0]),
    .q      (min_ones),
    .zero   (min_ones_zero),
    .borrow (min_ones_borrow)
  );

  // The top digit never borrows because 00:00 is never decremented.
  bcd_digit_down #(.MAX(BCD_MAX_DIGIT)) u_min_tens (
    .clk    (clk),
    .rst    (rst),
    .en     (min_ones_borrow),
    .ld     (do_load),
    .ld_val (preset_min[7:4]),
    .q      (min_tens),
    .zero   (min_tens_zero),
    .borrow (min_tens_borrow_unused)
  );

  assign min_bcd  = {min_tens, min_ones};
  assign sec_bcd  = {sec_tens, sec_ones};
  assign state    = state_q;
  assign expired  = expired_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed vector table, multi-cycle sequences and
// random strobes checked against a seconds-based reference model.
module tb_countdown_timer;

  localparam logic [1:0] M_IDLE  = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_PAUSE = 2'b10;
  localparam logic [1:0] M_DONE  = 2'b11;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] state;
  logic       expired;
  logic       alarm;
  logic       load_err;

  countdown_timer #(.MAX_MIN(59)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .start      (start),
    .pause      (pause),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .state      (state),
    .expired    (expired),
    .alarm      (alarm),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining time kept as plain seconds.
  int         m_total;
  logic [1:0] m_state;
  logic       m_exp;
  logic       m_alarm;
  logic       m_lerr;

  typedef struct {
    string      name;
    logic       ld;
    logic       st;
    logic       pa;
    logic       tk;
    logic [7:0] pm;
    logic [7:0] ps;
    logic [7:0] e_min;
    logic [7:0] e_sec;
    logic [1:0] e_state;
    logic       e_exp;
    logic       e_alarm;
    logic       e_lerr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_total = 0;
    m_state = M_IDLE;
    m_exp   = 1'b0;
    m_alarm = 1'b0;
    m_lerr  = 1'b0;
  endtask

  task automatic model_step(input logic l, input logic s, input logic p, input logic t,
                            input logic [7:0] pm, input logic [7:0] ps);
    int mt, mo, stn, so;
    mt  = int'(pm[7:4]);
    mo  = int'(pm[3:0]);
    stn = int'(ps[7:4]);
    so  = int'(ps[3:0]);
    m_exp  = 1'b0;
    m_lerr = 1'b0;
    if (l) begin
      if (mt <= 9 && mo <= 9 && stn <= 5 && so <= 9 && (mt * 10 + mo) <= 59) begin
        m_total = (mt * 10 + mo) * 60 + stn * 10 + so;
        m_state = M_IDLE;
      end else begin
        m_lerr = 1'b1;
      end
    end else if (p && m_state == M_RUN) begin
      m_state = M_PAUSE;
    end else if (s && (m_state == M_IDLE || m_state == M_PAUSE) && m_total != 0) begin
      m_state = M_RUN;
    end else if (t && m_state == M_RUN && m_total > 0) begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_state = M_DONE;
        m_exp   = 1'b1;
      end
    end
    m_alarm = (m_state == M_DONE);
  endtask

  task automatic applyStimulus(input logic l, input logic s, input logic p, input logic t,
                               input logic [7:0] pm, input logic [7:0] ps);
    load       = l;
    start      = s;
    pause      = p;
    tick       = t;
    preset_min = pm;
    preset_sec = ps;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    tick  = 1'b0;
    model_step(l, s, p, t, pm, ps);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] e_min, input logic [7:0] e_sec,
                             input logic [1:0] e_state, input logic e_exp, input logic e_alarm,
                             input logic e_lerr);
    logic [20:0] act, req;
    act = {min_bcd, sec_bcd, state, expired, alarm, load_err};
    req = {e_min, e_sec, e_state, e_exp, e_alarm, e_lerr};
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual min=%h sec=%h st=%b exp=%b alarm=%b lerr=%b, required min=%h sec=%h st=%b exp=%b alarm=%b lerr=%b",
               name, min_bcd, sec_bcd, state, expired, alarm, load_err,
               e_min, e_sec, e_state, e_exp, e_alarm, e_lerr);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, to_bcd(m_total / 60), to_bcd(m_total % 60), m_state, m_exp, m_alarm, m_lerr);
  endtask

  task automatic addVec(input string name, input logic l, input logic s, input logic p, input logic t,
                        input logic [7:0] pm, input logic [7:0] ps, input logic [7:0] e_min,
                        input logic [7:0] e_sec, input logic [1:0] e_state, input logic e_exp,
                        input logic e_alarm, input logic e_lerr);
    vec_t v;
    v.name = name; v.ld = l; v.st = s; v.pa = p; v.tk = t; v.pm = pm; v.ps = ps;
    v.e_min = e_min; v.e_sec = e_sec; v.e_state = e_state;
    v.e_exp = e_exp; v.e_alarm = e_alarm; v.e_lerr = e_lerr;
    vecs.push_back(v);
  endtask

  int         exp_pulses;
  int         r;
  logic       rl, rs, rp, rt;
  logic [7:0] rpm, rps;

  initial begin
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    preset_min = 8'h00; preset_sec = 8'h00;
    model_reset();

    //      name           ld st pa tk  pm     ps     min    sec    state    ex al le
    addVec("load_0100",    1, 0, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, M_IDLE,  0, 0, 0);
    addVec("start_0100",   0, 1, 0, 0, 8'h00, 8'h00, 8'h01, 8'h00, M_RUN,   0, 0, 0);
    addVec("tick_0059",    0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h59, M_RUN,   0, 0, 0);
    addVec("load_in_run",  1, 0, 0, 0, 8'h10, 8'h00, 8'h10, 8'h00, M_IDLE,  0, 0, 0);
    addVec("start_tick",   0, 1, 0, 1, 8'h00, 8'h00, 8'h10, 8'h00, M_RUN,   0, 0, 0);
    addVec("tick_0959",    0, 0, 0, 1, 8'h00, 8'h00, 8'h09, 8'h59, M_RUN,   0, 0, 0);
    addVec("pause",        0, 0, 1, 0, 8'h00, 8'h00, 8'h09, 8'h59, M_PAUSE, 0, 0, 0);
    addVec("tick_paused",  0, 0, 0, 1, 8'h00, 8'h00, 8'h09, 8'h59, M_PAUSE, 0, 0, 0);
    addVec("bad_sec75",    1, 0, 0, 0, 8'h00, 8'h75, 8'h09, 8'h59, M_PAUSE, 0, 0, 1);
    addVec("bad_min9a",    1, 0, 0, 0, 8'h9A, 8'h00, 8'h09, 8'h59, M_PAUSE, 0, 0, 1);
    addVec("bad_min60",    1, 0, 0, 0, 8'h60, 8'h00, 8'h09, 8'h59, M_PAUSE, 0, 0, 1);
    addVec("load_0000",    1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, M_IDLE,  0, 0, 0);
    addVec("start_zero",   0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, M_IDLE,  0, 0, 0);
    addVec("load_start",   1, 1, 0, 0, 8'h00, 8'h05, 8'h00, 8'h05, M_IDLE,  0, 0, 0);
    addVec("start_0005",   0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h05, M_RUN,   0, 0, 0);
    addVec("pause_0005",   0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h05, M_PAUSE, 0, 0, 0);
    addVec("ptick1",       0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h05, M_PAUSE, 0, 0, 0);
    addVec("ptick2",       0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h05, M_PAUSE, 0, 0, 0);
    addVec("ptick3",       0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h05, M_PAUSE, 0, 0, 0);
    addVec("resume",       0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h05, M_RUN,   0, 0, 0);
    addVec("tick_0004",    0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h04, M_RUN,   0, 0, 0);
    addVec("tick_0003",    0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h03, M_RUN,   0, 0, 0);
    addVec("load_5959",    1, 0, 0, 0, 8'h59, 8'h59, 8'h59, 8'h59, M_IDLE,  0, 0, 0);
    addVec("load_0001",    1, 0, 0, 0, 8'h00, 8'h01, 8'h00, 8'h01, M_IDLE,  0, 0, 0);
    addVec("start_0001",   0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, M_RUN,   0, 0, 0);
    addVec("expire",       0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, M_DONE,  1, 1, 0);
    addVec("done_tick",    0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, M_DONE,  0, 1, 0);
    addVec("done_start",   0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, M_DONE,  0, 1, 0);
    addVec("done_pause",   0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, M_DONE,  0, 1, 0);
    addVec("done_badld",   1, 0, 0, 0, 8'h00, 8'hA0, 8'h00, 8'h00, M_DONE,  0, 1, 1);
    addVec("done_load",    1, 0, 0, 0, 8'h00, 8'h02, 8'h00, 8'h02, M_IDLE,  0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 8'h00, 8'h00, M_IDLE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].pa, vecs[i].tk, vecs[i].pm, vecs[i].ps);
      checkOutput(vecs[i].name, vecs[i].e_min, vecs[i].e_sec, vecs[i].e_state,
                  vecs[i].e_exp, vecs[i].e_alarm, vecs[i].e_lerr);
    end

    // Asynchronous reset while running at 12:34, observed before any clock edge.
    applyStimulus(1, 0, 0, 0, 8'h12, 8'h34);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    checkOutput("run_1234", 8'h12, 8'h34, M_RUN, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 8'h00, 8'h00, M_IDLE, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Full minute with back-to-back ticks, counting expiry pulses.
    applyStimulus(1, 0, 0, 0, 8'h01, 8'h00);
    applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
    exp_pulses = 0;
    for (int i = 0; i < 62; i++) begin
      applyStimulus(0, 0, 0, 1, 8'h00, 8'h00);
      if (expired) exp_pulses++;
      checkModel("minute_run");
    end
    n_checks++;
    if (exp_pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL expired_count: actual %0d pulses, required 1", exp_pulses);
    end
    checkOutput("minute_done", 8'h00, 8'h00, M_DONE, 1'b0, 1'b1, 1'b0);

    // Random strobes against the reference model.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      rl = 1'b0; rs = 1'b0; rp = 1'b0; rt = 1'b0;
      rpm = 8'h00; rps = 8'h00;
      if (r < 6) begin
        rl = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          rpm = 8'($urandom);
          rps = 8'($urandom);
        end else begin
          rpm = to_bcd(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 59)) : int'($urandom_range(0, 1)));
          rps = to_bcd(int'($urandom_range(0, 20)));
        end
        rs = ($urandom_range(0, 3) == 0);
      end else if (r < 14) begin
        rs = 1'b1;
        rt = ($urandom_range(0, 3) == 0);
      end else if (r < 20) begin
        rp = 1'b1;
      end else if (r < 88) begin
        rt = 1'b1;
      end
      applyStimulus(rl, rs, rp, rt, rpm, rps);
      checkModel("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
